// File: rtl/ksa_pkg.sv
// Shared definitions for the RC4 key-search controller: FSM state encoding,
// LEDR status patterns and the default key width.
package ksa_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_SEARCH = 3'd2,
    S_FOUND  = 3'd3,
    S_FAIL   = 3'd4
  } state_t;

  localparam logic [9:0] LED_FOUND = 10'h3FF;
  localparam logic [9:0] LED_FAIL  = 10'h2AA;
  localparam logic [9:0] LED_BUSY  = 10'h001;
  localparam logic [9:0] LED_OFF   = 10'h000;

  localparam int KEY_W_DEF = 24;

endpackage

// File: rtl/ksa_prio_enc.sv
// Lowest-index-wins priority encoder over the per-core request bits.
// Purely combinational.
module ksa_prio_enc #(
  parameter int NUM_CORES = 4,
  parameter int IDX_W     = 4
) (
  input  logic [NUM_CORES-1:0] req,
  output logic                 any,
  output logic [IDX_W-1:0]     idx
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    any = |req;
    idx = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/ksa_multicore_ctrl.sv
// Launch/arbitrate/stop controller for a bank of RC4 key-search cores.
// Optional search-cycle counter is built only when KSA_CYCLE_CNT_EN is defined.
module ksa_multicore_ctrl
  import ksa_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int KEY_W     = KEY_W_DEF,
  parameter int IDX_W     = 4,
  parameter int CNT_W     = 32
) (
  input  logic                       CLOCK_50,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       abort,
  input  logic [NUM_CORES-1:0]       core_found,
  input  logic [NUM_CORES-1:0]       core_exhausted,
  input  logic [NUM_CORES*KEY_W-1:0] core_key,
  output logic                       core_start,
  output logic                       core_stop,
  output logic                       busy,
  output logic                       found,
  output logic                       failed,
  output logic [IDX_W-1:0]           winner_idx,
  output logic [KEY_W-1:0]           key_out,
  output logic [CNT_W-1:0]           cycle_cnt,
  output logic [9:0]                 LEDR,
  output logic [2:0]                 state_dbg
);

  // Handshake: there is no valid/ready pair here. start is a level sampled only
  // in IDLE/FOUND/FAIL; core_found/core_exhausted are levels sampled only in
  // SEARCH; core_start is a one-cycle pulse and core_stop a registered level.

  state_t state, next_state;
  logic   abort_go;
  logic   any_found;
  logic [IDX_W-1:0] win_idx;
  logic [KEY_W-1:0] sel_key;

  ksa_prio_enc #(.NUM_CORES(NUM_CORES), .IDX_W(IDX_W)) u_prio (
    .req (core_found),
    .any (any_found),
    .idx (win_idx)
  );

  always_comb begin
    sel_key = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (IDX_W'(i) == win_idx) sel_key = core_key[i*KEY_W +: KEY_W];
    end
  end

  always_comb begin
    next_state = state;
    abort_go   = 1'b0;
    case (state)
      S_IDLE:   if (start) next_state = S_LAUNCH;
      S_LAUNCH: next_state = S_SEARCH;
      S_SEARCH: begin
        if (any_found)            next_state = S_FOUND;
        else if (&core_exhausted) next_state = S_FAIL;
        else if (abort) begin
          next_state = S_IDLE;
          abort_go   = 1'b1;
        end
      end
      S_FOUND, S_FAIL: begin
        if (abort) begin
          next_state = S_IDLE;
          abort_go   = 1'b1;
        end else if (start) begin
          next_state = S_LAUNCH;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      core_stop  <= 1'b0;
      winner_idx <= '0;
      key_out    <= '0;
    end else begin
      state     <= next_state;
      core_stop <= (next_state == S_FOUND) || (next_state == S_FAIL) || abort_go;
      if (next_state == S_LAUNCH) begin
        winner_idx <= '0;
        key_out    <= '0;
      end else if (state == S_SEARCH && any_found) begin
        // Write-once: only the SEARCH->FOUND edge ever loads the latch.
        winner_idx <= win_idx;
        key_out    <= sel_key;
      end
    end
  end

`ifdef KSA_CYCLE_CNT_EN
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      cycle_cnt <= '0;
    end else if (next_state == S_LAUNCH) begin
      cycle_cnt <= '0;
    end else if (state == S_SEARCH && cycle_cnt != {CNT_W{1'b1}}) begin
      cycle_cnt <= cycle_cnt + 1'b1;
    end
  end
`else
  assign cycle_cnt = '0;
`endif

  always_comb begin
    core_start = (state == S_LAUNCH);
    busy       = (state == S_LAUNCH) || (state == S_SEARCH);
    found      = (state == S_FOUND);
    failed     = (state == S_FAIL);
    state_dbg  = state;
    case (state)
      S_FOUND:  LEDR = LED_FOUND;
      S_FAIL:   LEDR = LED_FAIL;
      S_SEARCH: LEDR = LED_BUSY;
      default:  LEDR = LED_OFF;
    endcase
  end

endmodule

// File: tb/tb_ksa_multicore_ctrl.sv
// Directed bench for ksa_multicore_ctrl (NUM_CORES=4, KEY_W=24): a vector table
// of single-cycle search outcomes plus hand-written multi-cycle sequences.
module tb_ksa_multicore_ctrl;

  localparam int N  = 4;
  localparam int KW = 24;
  localparam int IW = 4;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst, start, abort;
  logic [N-1:0]  cf, ce;
  logic [N*KW-1:0] ck;
  logic          core_start, core_stop, busy, found, failed;
  logic [IW-1:0] winner_idx;
  logic [KW-1:0] key_out;
  logic [CW-1:0] cycle_cnt;
  logic [9:0]    ledr;
  logic [2:0]    state_dbg;

  int checks   = 0;
  int failures = 0;

  ksa_multicore_ctrl #(.NUM_CORES(N), .KEY_W(KW), .IDX_W(IW), .CNT_W(CW)) dut (
    .CLOCK_50       (clk),
    .reset          (rst),
    .start          (start),
    .abort          (abort),
    .core_found     (cf),
    .core_exhausted (ce),
    .core_key       (ck),
    .core_start     (core_start),
    .core_stop      (core_stop),
    .busy           (busy),
    .found          (found),
    .failed         (failed),
    .winner_idx     (winner_idx),
    .key_out        (key_out),
    .cycle_cnt      (cycle_cnt),
    .LEDR           (ledr),
    .state_dbg      (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; cf = '0; ce = '0; ck = '0;
    step();
    rst = 1'b0;
    step();
  endtask

  // Leaves the DUT one sample after entering SEARCH.
  task automatic launch(input string tag);
    start = 1'b1;
    step();
    chk({tag, "_launch_core_start"}, 32'(core_start), 32'd1);
    chk({tag, "_launch_found"},      32'(found),      32'd0);
    chk({tag, "_launch_key"},        32'(key_out),    32'd0);
    chk({tag, "_launch_cnt"},        cycle_cnt,       32'd0);
    start = 1'b0;
    step();
    chk({tag, "_search_busy"},       32'(busy),       32'd1);
  endtask

  typedef struct {
    logic [N-1:0]    cf;
    logic [N-1:0]    ce;
    logic [N*KW-1:0] ck;
    logic            e_found;
    logic            e_failed;
    logic            e_stop;
    logic [IW-1:0]   e_win;
    logic [KW-1:0]   e_key;
    logic [9:0]      e_led;
  } vec_t;

  vec_t vt[7];
  logic [CW-1:0] exp_cnt100;

  initial begin
`ifdef KSA_CYCLE_CNT_EN
    exp_cnt100 = 32'd100;
`else
    exp_cnt100 = 32'd0;
`endif
    vt[0] = '{4'b0100, 4'b0000, {24'h333333, 24'h000249, 24'h111111, 24'h000000},
              1'b1, 1'b0, 1'b1, 4'd2, 24'h000249, 10'h3FF};
    vt[1] = '{4'b1010, 4'b0000, {24'h3FFFFF, 24'h222222, 24'h00A5A5, 24'h000000},
              1'b1, 1'b0, 1'b1, 4'd1, 24'h00A5A5, 10'h3FF};
    vt[2] = '{4'b0001, 4'b1111, {24'h333333, 24'h222222, 24'h111111, 24'h0ABCDE},
              1'b1, 1'b0, 1'b1, 4'd0, 24'h0ABCDE, 10'h3FF};
    vt[3] = '{4'b0000, 4'b1111, {24'h333333, 24'h222222, 24'h111111, 24'h0ABCDE},
              1'b0, 1'b1, 1'b1, 4'd0, 24'h000000, 10'h2AA};
    vt[4] = '{4'b1000, 4'b0000, {24'h7654AB, 24'h222222, 24'h111111, 24'h0ABCDE},
              1'b1, 1'b0, 1'b1, 4'd3, 24'h7654AB, 10'h3FF};
    vt[5] = '{4'b1111, 4'b0000, {24'h333333, 24'h222222, 24'h111111, 24'hC0FFEE},
              1'b1, 1'b0, 1'b1, 4'd0, 24'hC0FFEE, 10'h3FF};
    vt[6] = '{4'b0000, 4'b0111, {24'h333333, 24'h222222, 24'h111111, 24'h0ABCDE},
              1'b0, 1'b0, 1'b0, 4'd0, 24'h000000, 10'h001};

    do_reset();
    chk("reset_state", 32'(state_dbg), 32'd0);
    chk("reset_ledr",  32'(ledr),      32'd0);
    chk("reset_stop",  32'(core_stop), 32'd0);

    // Table-driven single-cycle outcomes
    for (int i = 0; i < 7; i++) begin
      do_reset();
      launch($sformatf("v%0d", i));
      step();
      cf = vt[i].cf; ce = vt[i].ce; ck = vt[i].ck;
      step();
      cf = '0; ce = '0;
      chk($sformatf("v%0d_found", i),  32'(found),      32'(vt[i].e_found));
      chk($sformatf("v%0d_failed", i), 32'(failed),     32'(vt[i].e_failed));
      chk($sformatf("v%0d_stop", i),   32'(core_stop),  32'(vt[i].e_stop));
      chk($sformatf("v%0d_win", i),    32'(winner_idx), 32'(vt[i].e_win));
      chk($sformatf("v%0d_key", i),    32'(key_out),    32'(vt[i].e_key));
      chk($sformatf("v%0d_ledr", i),   32'(ledr),       32'(vt[i].e_led));
    end

    // Single winner after 100 SEARCH cycles
    do_reset();
    launch("t1");
    ck = {24'h333333, 24'h000249, 24'h111111, 24'h000000};
    repeat (99) step();
    chk("t1_still_search", 32'(state_dbg), 32'd2);
    cf = 4'b0100;
    step();
    chk("t1_found",  32'(found),      32'd1);
    chk("t1_win",    32'(winner_idx), 32'd2);
    chk("t1_key",    32'(key_out),    32'h000249);
    chk("t1_stop",   32'(core_stop),  32'd1);
    chk("t1_ledr",   32'(ledr),       32'h3FF);
    chk("t1_cnt",    cycle_cnt,       exp_cnt100);
    // Late report after stop must not touch the latch
    cf = 4'b0001; ck = {24'h333333, 24'h222222, 24'h111111, 24'hBADBAD};
    repeat (3) step();
    chk("t1_late_win", 32'(winner_idx), 32'd2);
    chk("t1_late_key", 32'(key_out),    32'h000249);
    chk("t1_hold_cnt", cycle_cnt,       exp_cnt100);
    cf = '0;

    // Restart from FOUND
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t6_core_start", 32'(core_start), 32'd1);
    chk("t6_found_clr",  32'(found),      32'd0);
    chk("t6_key_clr",    32'(key_out),    32'd0);
    chk("t6_win_clr",    32'(winner_idx), 32'd0);
    chk("t6_cnt_clr",    cycle_cnt,       32'd0);
    chk("t6_stop_low",   32'(core_stop),  32'd0);
    step();
    chk("t6_pulse_end",  32'(core_start), 32'd0);
    chk("t6_ledr_busy",  32'(ledr),       32'h001);

    // Abort in SEARCH: back to IDLE with a one-cycle stop
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t5_abort_state", 32'(state_dbg), 32'd0);
    chk("t5_abort_stop",  32'(core_stop), 32'd1);
    chk("t5_abort_busy",  32'(busy),      32'd0);
    step();
    chk("t5_abort_stop_end", 32'(core_stop), 32'd0);
    start = 1'b1;  // start is honoured again from IDLE
    step();
    start = 1'b0;
    chk("t5_relaunch", 32'(core_start), 32'd1);

    // Exhaustion one bit at a time
    do_reset();
    launch("t3");
    ce = 4'b0001; step(); chk("t3_e1_failed", 32'(failed), 32'd0);
    ce = 4'b0011; step(); chk("t3_e2_failed", 32'(failed), 32'd0);
    ce = 4'b0111; step(); chk("t3_e3_failed", 32'(failed), 32'd0);
    ce = 4'b1111; step();
    chk("t3_failed", 32'(failed),    32'd1);
    chk("t3_found",  32'(found),     32'd0);
    chk("t3_stop",   32'(core_stop), 32'd1);
    chk("t3_ledr",   32'(ledr),      32'h2AA);
    // Abort out of FAIL clears failed
    abort = 1'b1;
    step();
    abort = 1'b0; ce = '0;
    chk("t3_abort_failed", 32'(failed),    32'd0);
    chk("t3_abort_stop",   32'(core_stop), 32'd1);
    chk("t3_abort_state",  32'(state_dbg), 32'd0);

    // Asynchronous reset mid-search, off the clock edge
    do_reset();
    ck = {24'h333333, 24'h000249, 24'h111111, 24'h000000};
    launch("t5r");
    repeat (5) step();
    #2;
    rst = 1'b1;
    #1;
    chk("t5r_state", 32'(state_dbg), 32'd0);
    chk("t5r_busy",  32'(busy),      32'd0);
    chk("t5r_ledr",  32'(ledr),      32'd0);
    chk("t5r_cnt",   cycle_cnt,      32'd0);
    chk("t5r_stop",  32'(core_stop), 32'd0);
    chk("t5r_start", 32'(core_start), 32'd0);
    step();
    rst = 1'b0;
    step();
    chk("t5r_idle_after", 32'(state_dbg), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
